// File: rtl/muldiv_sequencer.sv
// RV32M execution unit for EX: a shared multi-cycle multiplier and a radix-2 restoring divider.
// It holds the pipeline through STALL and produces one RESULT per accepted instruction.
module muldiv_sequencer #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_MAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES : XLEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q;
  logic [CNT_W-1:0]  cnt;
  logic              q_sign, r_sign;

  // Decode of the instruction presented in IDLE.
  logic            accept, in_is_mul, in_signed_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign accept        = (state == S_IDLE) && START && !FLUSH;
  assign in_is_mul     = !OP[2];
  assign in_signed_div = OP[2] && !OP[0];
  assign a_mag         = (in_signed_div && OPERAND_A[XLEN-1]) ? -OPERAND_A : OPERAND_A;
  assign b_mag         = (in_signed_div && OPERAND_B[XLEN-1]) ? -OPERAND_B : OPERAND_B;
  assign div_zero      = (OPERAND_B == '0);
  assign div_ovf       = in_signed_div && (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}})
                         && (OPERAND_B == '1);

  // Low 2*XLEN bits of the product of the extended operands equal the signed/unsigned product.
  logic            a_ext, b_ext;
  logic [2*XLEN-1:0] product;

  assign a_ext   = a_q[XLEN-1] && ((op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10));
  assign b_ext   = b_q[XLEN-1] && (op_q[1:0] == 2'b01);
  assign product = {{XLEN{a_ext}}, a_q} * {{XLEN{b_ext}}, b_q};

  // Divider step: quo_q doubles as the dividend shift register, MSB first.
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] rem_next;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign rem_next  = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_is_mul)               state_next = S_MUL;
          else if (div_zero || div_ovf) state_next = S_FIXUP;
          else                          state_next = S_DIV;
        end
      end
      S_MUL:   if (cnt == '0) state_next = S_DONE;
      S_DIV:   if (cnt == '0) state_next = S_FIXUP;
      S_FIXUP: if (cnt == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (FLUSH) state_next = S_IDLE;
  end

  assign STALL = accept || (state == S_MUL) || (state == S_DIV) || (state == S_FIXUP);
  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_DONE);

  // FIXUP runs two steps: cnt==1 applies the signs, cnt==0 selects and loads RESULT.
  // Divide special cases preload their answers and enter at the cnt==0 step.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt    <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      RESULT <= '0;
    end else if (!FLUSH) begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= OP;
            a_q    <= in_is_mul ? OPERAND_A : a_mag;
            b_q    <= in_is_mul ? OPERAND_B : b_mag;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            if (in_is_mul) begin
              cnt <= CNT_W'(MUL_CYCLES - 1);
            end else if (div_zero) begin
              quo_q <= '1;
              rem_q <= OPERAND_A;
              cnt   <= '0;
            end else if (div_ovf) begin
              quo_q <= {1'b1, {(XLEN-1){1'b0}}};
              rem_q <= '0;
              cnt   <= '0;
            end else begin
              quo_q  <= a_mag;
              rem_q  <= '0;
              cnt    <= CNT_W'(XLEN - 1);
              q_sign <= in_signed_div && (OPERAND_A[XLEN-1] ^ OPERAND_B[XLEN-1]);
              r_sign <= in_signed_div && OPERAND_A[XLEN-1];
            end
          end
        end
        S_MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            RESULT <= (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[XLEN-2:0], rem_ge};
          cnt   <= (cnt == '0) ? CNT_W'(1) : cnt - 1'b1;
        end
        S_FIXUP: begin
          if (cnt != '0) begin
            if (q_sign) quo_q <= -quo_q;
            if (r_sign) rem_q <= -rem_q;
            cnt <= '0;
          end else begin
            RESULT <= op_q[1] ? rem_q : quo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, STALL/DONE framing,
// RISC-V divide corner cases, flush, reset and back-to-back issue.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'd0;
  logic [31:0] OPERAND_A = '0;
  logic [31:0] OPERAND_B = '0;
  logic        FLUSH = 1'b0;
  logic        STALL, BUSY, DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_sequencer #(.XLEN(32), .MUL_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .FLUSH(FLUSH),
    .STALL(STALL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE; exp_lat is the edge count after acceptance at which DONE shows.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int lat;
    int stalls;
    OP = op; OPERAND_A = a; OPERAND_B = b; START = 1'b1; FLUSH = 1'b0;
    #1;
    check({tag, " stall_on_request"}, 32'(STALL), 32'd1);
    @(posedge CLK); #1;
    OP = ~op; OPERAND_A = ~a; OPERAND_B = ~b;
    lat = 0;
    stalls = 0;
    while (!DONE && lat < 100) begin
      stalls += int'(STALL);
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " done_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, " result"}, RESULT, exp);
    check({tag, " stall_in_done"}, 32'(STALL), 32'd0);
    if (!hold) begin
      START = 1'b0;
      @(posedge CLK); #1;
      check({tag, " done_one_cycle"}, 32'(DONE), 32'd0);
      check({tag, " idle_after"}, 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    int dones;
    logic [31:0] prev;

    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset result", RESULT, 32'h0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    check("reset stall", 32'(STALL), 32'd0);

    run_op("mul",    F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 4, 1'b0);
    run_op("mulhu",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 1'b0);
    run_op("mulh",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4, 1'b0);
    run_op("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0);
    run_op("div",    F_DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 34, 1'b0);
    run_op("rem",    F_REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34, 1'b0);
    run_op("divu",   F_DIVU,   32'd100,       32'd7,         32'd14,        34, 1'b0);
    run_op("remu",   F_REMU,   32'd100,       32'd7,         32'd2,         34, 1'b0);
    run_op("divu_max", F_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, 1'b0);
    run_op("div0",   F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu0",  F_REMU,   32'd5,         32'd0,         32'd5,         1, 1'b0);
    run_op("div_ovf", F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", F_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1'b0);

    // Flush partway through a divide: no DONE, RESULT keeps the previous value.
    prev = 32'h0;
    OP = F_DIVU; OPERAND_A = 32'd100; OPERAND_B = 32'd7; START = 1'b1;
    @(posedge CLK); #1;
    repeat (10) @(posedge CLK);
    #1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    check("flush busy", 32'(BUSY), 32'd0);
    check("flush done", 32'(DONE), 32'd0);
    check("flush result", RESULT, prev);
    FLUSH = 1'b0; START = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      dones += int'(DONE);
    end
    check("flush no_done", 32'(dones), 32'd0);
    check("flush result_held", RESULT, prev);

    // Reset in the middle of a multiply.
    run_op("pre_reset", F_MUL, 32'd3, 32'd5, 32'd15, 4, 1'b0);
    OP = F_MUL; OPERAND_A = 32'd9; OPERAND_B = 32'd9; START = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1; START = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("mid_reset result", RESULT, 32'h0);
    check("mid_reset busy", 32'(BUSY), 32'd0);
    check("mid_reset done", 32'(DONE), 32'd0);
    check("mid_reset stall", 32'(STALL), 32'd0);
    dones = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      dones += int'(DONE);
    end
    check("mid_reset no_done", 32'(dones), 32'd0);

    // Back-to-back with START held: the second op is accepted the edge after the IDLE cycle.
    run_op("b2b_mul", F_MUL, 32'd6, 32'd7, 32'd42, 4, 1'b1);
    @(posedge CLK); #1;
    check("b2b gap_done", 32'(DONE), 32'd0);
    check("b2b gap_busy", 32'(BUSY), 32'd0);
    run_op("b2b_divu", F_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
